sprite_motion: RTL



---
 rtl/sprite_motion.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sprite_motion.sv
// Square sprite that moves once per frame and bounces off the visible-area edges,
// plus a registered per-pixel hit flag. Define SPRITE_WRAP_EN to wrap instead of bounce.
module sprite_motion #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SIZE     = 32,
    parameter int unsigned STEP     = 2,
    parameter int unsigned INIT_X   = 304,
    parameter int unsigned INIT_Y   = 224
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vsync_i,
    input  logic       pause_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       activeVideo_i,
    output logic [9:0] obj_x_o,
    output logic [9:0] obj_y_o,
    output logic       hit_o,
    output logic       frame_tick_o
);

    localparam logic [10:0] H_A = 11'(H_ACTIVE);
    localparam logic [10:0] V_A = 11'(V_ACTIVE);
    localparam logic [10:0] SZ  = 11'(SIZE);
    localparam logic [10:0] ST  = 11'(STEP);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e     state_q, state_d;
    logic       vsync_q;
    logic       tick_q;
    logic       hit_q, hit_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic [9:0] obj_x_q, obj_x_d;
    logic [9:0] obj_y_q, obj_y_d;
    logic       move;

    // Returns {dir, pos} after one step; dir=1 means right/down.
`ifdef SPRITE_WRAP_EN
    function automatic logic [10:0] stepAxis(input logic [9:0] pos, input logic dir,
                                             input logic [10:0] limit);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + ST > limit - 11'd1) return {1'b1, 10'(p + ST - limit)};
            return {1'b1, 10'(p + ST)};
        end
        if (p < ST) return {1'b0, 10'(p + limit - ST)};
        return {1'b0, 10'(p - ST)};
    endfunction

    function automatic logic inSpan(input logic [9:0] c, input logic [9:0] pos,
                                    input logic [10:0] limit);
        logic [10:0] cc, pp, ee;
        cc = {1'b0, c};
        pp = {1'b0, pos};
        ee = pp + SZ;
        if (ee > limit) return (cc >= pp) || (cc < ee - limit);
        return (cc >= pp) && (cc < ee);
    endfunction
`else
    function automatic logic [10:0] stepAxis(input logic [9:0] pos, input logic dir,
                                             input logic [10:0] limit);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + SZ + ST > limit) return {1'b0, 10'(limit - SZ)};
            return {1'b1, 10'(p + ST)};
        end
        if (p < ST) return {1'b1, 10'd0};
        return {1'b0, 10'(p - ST)};
    endfunction

    function automatic logic inSpan(input logic [9:0] c, input logic [9:0] pos);
        logic [10:0] cc, pp;
        cc = {1'b0, c};
        pp = {1'b0, pos};
        return (cc >= pp) && (cc < pp + SZ);
    endfunction
`endif

    // pause only matters on tick cycles; IDLE swallows the first tick without moving.
    always_comb begin
        state_d = state_q;
        move    = 1'b0;
        if (tick_q) begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (pause_i) state_d = HOLD;
                    else         move    = 1'b1;
                end
                HOLD: begin
                    if (!pause_i) begin
                        state_d = RUN;
                        move    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        {dx_d, obj_x_d} = {dx_q, obj_x_q};
        {dy_d, obj_y_d} = {dy_q, obj_y_q};
        if (move) begin
            {dx_d, obj_x_d} = stepAxis(obj_x_q, dx_q, H_A);
            {dy_d, obj_y_d} = stepAxis(obj_y_q, dy_q, V_A);
        end
`ifdef SPRITE_WRAP_EN
        hit_d = activeVideo_i & inSpan(x_i, obj_x_q, H_A) & inSpan(y_i, obj_y_q, V_A);
`else
        hit_d = activeVideo_i & inSpan(x_i, obj_x_q) & inSpan(y_i, obj_y_q);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
            hit_q   <= 1'b0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            obj_x_q <= 10'(INIT_X);
            obj_y_q <= 10'(INIT_Y);
        end else begin
            state_q <= state_d;
            vsync_q <= vsync_i;
            tick_q  <= vsync_q & ~vsync_i;
            hit_q   <= hit_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            obj_x_q <= obj_x_d;
            obj_y_q <= obj_y_d;
        end
    end

    assign obj_x_o      = obj_x_q;
    assign obj_y_o      = obj_y_q;
    assign hit_o        = hit_q;
    assign frame_tick_o = tick_q;

endmodule
